// File: rtl/grant_arbiter_fsm.sv
// Round-robin grant arbiter: IDLE -> GRANT -> REVOKE -> IDLE, with voluntary
// release via done, optional hold timeout, and a revoke/acknowledge handshake.
module grant_arbiter_fsm #(
  parameter int N_CH     = 4,
  parameter int HOLD_MAX = 16
) (
  input  logic                      i_ck,
  input  logic                      i_arst_n,
  input  logic [N_CH-1:0]           i_req,
  input  logic [N_CH-1:0]           i_done,
  input  logic [N_CH-1:0]           i_revokeAck,
  output logic [N_CH-1:0]           o_grant,
  output logic [N_CH-1:0]           o_revoke,
  output logic [$clog2(N_CH)-1:0]   o_grantIdx,
  output logic                      o_busy,
  output logic                      o_timeout
);

  localparam int IDX_W = $clog2(N_CH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    REVOKE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [7:0]       hold_q, hold_d;
  logic             timeout_q, timeout_d;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] cand;
  logic             hold_hit;

  // Scan offsets from farthest to nearest so the nearest requester after
  // last_q is the final assignment, i.e. the round-robin winner.
  always_comb begin
    winner = last_q;
    cand   = last_q;
    for (int unsigned i = N_CH; i >= 1; i--) begin
      cand = IDX_W'((32'(last_q) + i) % 32'(N_CH));
      if (i_req[cand]) winner = cand;
    end
  end

  assign hold_hit = (HOLD_MAX > 0) && (hold_q == 8'(HOLD_MAX - 1));

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|i_req) begin
          state_d = GRANT;
          owner_d = winner;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (hold_q != '1) hold_d = hold_q + 8'd1;
        // Voluntary release takes precedence over the timeout.
        if (i_done[owner_q]) begin
          state_d = REVOKE;
        end else if (hold_hit) begin
          state_d   = REVOKE;
          timeout_d = 1'b1;
        end
      end
      REVOKE: begin
        if (i_revokeAck[owner_q]) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_ck or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q   <= IDLE;
      owner_q   <= IDX_W'(N_CH - 1);
      last_q    <= IDX_W'(N_CH - 1);
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  // Outputs decode registered state only.
  always_comb begin
    o_grant  = '0;
    o_revoke = '0;
    if (state_q == GRANT)  o_grant[owner_q]  = 1'b1;
    if (state_q == REVOKE) o_revoke[owner_q] = 1'b1;
  end

  assign o_grantIdx = (state_q == IDLE) ? last_q : owner_q;
  assign o_busy     = (state_q != IDLE);
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_grant_arbiter_fsm.sv
// Self-checking bench for grant_arbiter_fsm (N_CH=4, HOLD_MAX=8); expected
// grant owners are queued when requests are driven and popped on each grant.
module tb_grant_arbiter_fsm;

  logic       i_ck;
  logic       i_arst_n;
  logic [3:0] i_req, i_done, i_revokeAck;
  logic [3:0] o_grant, o_revoke;
  logic [1:0] o_grantIdx;
  logic       o_busy, o_timeout;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  grant_arbiter_fsm #(.N_CH(4), .HOLD_MAX(8)) dut (
    .i_ck        (i_ck),
    .i_arst_n    (i_arst_n),
    .i_req       (i_req),
    .i_done      (i_done),
    .i_revokeAck (i_revokeAck),
    .o_grant     (o_grant),
    .o_revoke    (o_revoke),
    .o_grantIdx  (o_grantIdx),
    .o_busy      (o_busy),
    .o_timeout   (o_timeout)
  );

  initial i_ck = 1'b0;
  always #5 i_ck = ~i_ck;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge i_ck);
    #1;
  endtask

  task automatic wait_grant(input int budget, output int n);
    n = 0;
    while (o_grant == 4'b0 && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic release_owner(input int ch);
    i_done = 4'b0001 << ch;
    tick();
    i_done = '0;
    i_revokeAck = 4'b0001 << ch;
    tick();
    i_revokeAck = '0;
  endtask

  task automatic test_reset;
    i_arst_n = 1'b0; i_req = '0; i_done = '0; i_revokeAck = '0;
    repeat (3) tick();
    checks++; if (o_grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", o_grant); end
    checks++; if (o_revoke !== 4'b0000) begin errors++; $display("FAIL reset_revoke: got %b expected 0000", o_revoke); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", o_timeout); end
    checks++; if (o_grantIdx !== 2'd3) begin errors++; $display("FAIL reset_idx: got %0d expected 3", o_grantIdx); end
    i_arst_n = 1'b1;
  endtask

  task automatic test_basic;
    int e;
    i_req = 4'b1010;
    exp_q.push_back(1);
    tick();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    checks++; if (o_grant !== (4'b0001 << e)) begin errors++; $display("FAIL basic_grant: got %b expected ch%0d", o_grant, e); end
    checks++; if (o_grantIdx !== 2'(e)) begin errors++; $display("FAIL basic_idx: got %0d expected %0d", o_grantIdx, e); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", o_busy); end
    i_done = 4'b0010;
    tick();
    i_done = '0;
    checks++; if (o_revoke !== 4'b0010 || o_grant !== 4'b0000) begin errors++; $display("FAIL basic_revoke: got rev=%b gnt=%b expected rev=0010 gnt=0000", o_revoke, o_grant); end
    checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL basic_no_timeout: got %b expected 0", o_timeout); end
    i_revokeAck = 4'b0010;
    tick();
    i_revokeAck = '0;
    checks++; if (o_busy !== 1'b0 || o_grantIdx !== 2'd1) begin errors++; $display("FAIL basic_idle: got busy=%b idx=%0d expected busy=0 idx=1", o_busy, o_grantIdx); end
    exp_q.push_back(3);
    tick();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    checks++; if (o_grant !== (4'b0001 << e)) begin errors++; $display("FAIL basic_next_grant: got %b expected ch%0d", o_grant, e); end
    i_req = '0;
    release_owner(3);
  endtask

  task automatic test_round_robin;
    int e, n;
    i_req = 4'b1111;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    for (int k = 0; k < 5; k++) begin
      wait_grant(4, n);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      checks++; if (o_grant !== (4'b0001 << e)) begin errors++; $display("FAIL rr_grant_%0d: got %b expected ch%0d", k, o_grant, e); end
      checks++; if (o_grantIdx !== 2'(e)) begin errors++; $display("FAIL rr_idx_%0d: got %0d expected %0d", k, o_grantIdx, e); end
      release_owner(e);
      checks++; if (o_busy !== 1'b0 || o_grant !== 4'b0000) begin errors++; $display("FAIL rr_idle_gap_%0d: got busy=%b gnt=%b expected busy=0 gnt=0000", k, o_busy, o_grant); end
    end
    i_req = '0;
  endtask

  task automatic test_timeout;
    int e, n;
    i_req = 4'b0100;
    exp_q.push_back(2);
    wait_grant(4, n);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    checks++; if (o_grant !== (4'b0001 << e)) begin errors++; $display("FAIL to_grant: got %b expected ch%0d", o_grant, e); end
    i_req = '0;
    for (int k = 1; k < 8; k++) begin
      tick();
      checks++; if (o_grant !== 4'b0100 || o_timeout !== 1'b0) begin errors++; $display("FAIL to_hold_%0d: got gnt=%b to=%b expected gnt=0100 to=0", k, o_grant, o_timeout); end
    end
    tick();
    checks++; if (o_revoke !== 4'b0100 || o_grant !== 4'b0000) begin errors++; $display("FAIL to_revoke: got rev=%b gnt=%b expected rev=0100 gnt=0000", o_revoke, o_grant); end
    checks++; if (o_timeout !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b expected 1", o_timeout); end
    tick();
    checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_width: got %b expected 0", o_timeout); end
    repeat (3) tick();
    checks++; if (o_revoke !== 4'b0100 || o_busy !== 1'b1) begin errors++; $display("FAIL to_wait_ack: got rev=%b busy=%b expected rev=0100 busy=1", o_revoke, o_busy); end
    i_revokeAck = 4'b0100;
    tick();
    i_revokeAck = '0;
    checks++; if (o_busy !== 1'b0 || o_grantIdx !== 2'd2) begin errors++; $display("FAIL to_idle: got busy=%b idx=%0d expected busy=0 idx=2", o_busy, o_grantIdx); end
  endtask

  task automatic test_done_at_limit;
    int e, n;
    i_req = 4'b0001;
    exp_q.push_back(0);
    wait_grant(4, n);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    checks++; if (o_grant !== (4'b0001 << e)) begin errors++; $display("FAIL lim_grant: got %b expected ch%0d", o_grant, e); end
    i_req = '0;
    repeat (7) tick();
    i_done = 4'b0001;
    tick();
    i_done = '0;
    checks++; if (o_revoke !== 4'b0001) begin errors++; $display("FAIL lim_revoke: got %b expected 0001", o_revoke); end
    checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL lim_no_timeout: got %b expected 0", o_timeout); end
    i_revokeAck = 4'b0001;
    tick();
    i_revokeAck = '0;
  endtask

  task automatic test_ignored;
    int e, n;
    i_req = 4'b0010;
    exp_q.push_back(1);
    wait_grant(4, n);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    checks++; if (o_grant !== (4'b0001 << e)) begin errors++; $display("FAIL ign_grant: got %b expected ch%0d", o_grant, e); end
    i_req = '0;
    i_done = 4'b0001;
    tick();
    checks++; if (o_grant !== 4'b0010) begin errors++; $display("FAIL ign_done: got %b expected 0010", o_grant); end
    i_done = 4'b0010;
    tick();
    i_done = '0;
    i_revokeAck = 4'b1000;
    tick();
    checks++; if (o_revoke !== 4'b0010 || o_busy !== 1'b1) begin errors++; $display("FAIL ign_ack: got rev=%b busy=%b expected rev=0010 busy=1", o_revoke, o_busy); end
    i_revokeAck = 4'b0010;
    tick();
    i_revokeAck = '0;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL ign_idle: got busy=%b expected 0", o_busy); end
  endtask

  task automatic test_async_reset;
    int e, n;
    i_req = 4'b0001;
    wait_grant(4, n);
    checks++; if (o_grant !== 4'b0001) begin errors++; $display("FAIL ar_pre_grant: got %b expected 0001", o_grant); end
    #2;
    i_arst_n = 1'b0;
    #1;
    checks++; if (o_grant !== 4'b0000 || o_busy !== 1'b0) begin errors++; $display("FAIL ar_drop: got gnt=%b busy=%b expected gnt=0000 busy=0", o_grant, o_busy); end
    checks++; if (o_grantIdx !== 2'd3) begin errors++; $display("FAIL ar_idx: got %0d expected 3", o_grantIdx); end
    i_req = 4'b1000;
    tick();
    i_arst_n = 1'b1;
    exp_q.push_back(3);
    tick();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    checks++; if (o_grant !== (4'b0001 << e) || o_grantIdx !== 2'(e)) begin errors++; $display("FAIL ar_regrant: got gnt=%b idx=%0d expected ch%0d", o_grant, o_grantIdx, e); end
    i_req = '0;
    release_owner(3);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_timeout();
    test_done_at_limit();
    test_ignored();
    test_async_reset();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
